// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU display path.
//   - opcode encodings LOAD..DISPLAY (0..7)
//   - HD44780 command bytes used by the display stage
//   - display controller state and byte-write phase enums
//   - mnemonic ROM: opcode + column (0..4) -> ASCII character
package mini_cpu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef enum logic [2:0] {
        ST_POWERUP_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_CONVERT,
        ST_LINE1,
        ST_LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_HOLD
    } byte_phase_t;

    function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [2:0] pos);
        logic [39:0] txt;
        logic [7:0]  ch;
        case (op)
            OP_LOAD:  txt = "LOAD ";
            OP_ADD:   txt = "ADD  ";
            OP_ADDI:  txt = "ADDI ";
            OP_SUB:   txt = "SUB  ";
            OP_SUBI:  txt = "SUBI ";
            OP_MUL:   txt = "MUL  ";
            OP_CLEAR: txt = "CLEAR";
            default:  txt = "DISP ";
        endcase
        case (pos)
            3'd0:    ch = txt[39:32];
            3'd1:    ch = txt[31:24];
            3'd2:    ch = txt[23:16];
            3'd3:    ch = txt[15:8];
            default: ch = txt[7:0];
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/bcd_converter_16.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a conversion of bin (ignored while busy)
//   bin          : 16-bit unsigned input
//   busy         : conversion in progress (16 iteration cycles)
//   done         : one-cycle pulse after the last iteration; bcd valid from here
//   bcd          : 5 BCD digits, most significant digit in [19:16]
module bcd_converter_16
    import mini_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [3:0]  iter_q;
    logic        running_q;
    logic        done_q;

    // add-3 correction for every digit >= 5 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= running_q && (iter_q == 4'd15);
            if (running_q) begin
                bcd_q   <= {bcd_adj[18:0], shift_q[15]};
                shift_q <= {shift_q[14:0], 1'b0};
                iter_q  <= iter_q + 4'd1;
                if (iter_q == 4'd15)
                    running_q <= 1'b0;
            end else if (start) begin
                shift_q   <= bin;
                bcd_q     <= '0;
                iter_q    <= '0;
                running_q <= 1'b1;
            end
        end
    end

    assign busy = running_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_result_display.sv
// Result display stage: shows the last instruction on a 16x2 HD44780 LCD
// (8-bit, write-only). Performs the power-up init sequence itself.
//   clk, reset_n     : 50 MHz clock, asynchronous active-low reset
//   start            : one-cycle refresh request; opcode/reg_idx/value captured
//   opcode, reg_idx  : line 1 "MNEMO Rnn"
//   value            : line 2 signed decimal "+nnnnn" / "-nnnnn"
//   busy             : high except in IDLE
//   lcd_data, lcd_rs, lcd_en : LCD bus; lcd_rw=0, lcd_on=1, lcd_blon=1
module lcd_result_display
    import mini_cpu_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
    parameter int unsigned EN_HIGH_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [3:0]  reg_idx,
    input  logic [15:0] value,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon
);

    localparam int unsigned MAX_A    = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int unsigned MAX_B    = (CMD_WAIT_CYCLES > EN_HIGH_CYCLES) ? CMD_WAIT_CYCLES : EN_HIGH_CYCLES;
    localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    lcd_state_t       state, state_n;
    byte_phase_t      phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n, hold_last;
    logic [4:0]       byte_idx, idx_n;
    logic             conv_wait, conv_wait_n;
    logic             pending;
    logic             load_byte, bcd_start, disp_load;
    logic [8:0]       next_byte;

    logic [2:0]  cap_opcode, disp_opcode;
    logic [3:0]  cap_reg, disp_reg;
    logic [15:0] cap_value, magnitude;
    logic        disp_neg;

    logic        bcd_busy, bcd_done;
    logic [19:0] bcd_digits;

    assign magnitude = cap_value[15] ? (~cap_value + 16'd1) : cap_value;

    bcd_converter_16 u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bcd_start),
        .bin     (magnitude),
        .busy    (bcd_busy),
        .done    (bcd_done),
        .bcd     (bcd_digits)
    );

    // {rs, data} for byte idx of a sending state; idx 0 of a line is its address command
    function automatic logic [8:0] byte_for(input lcd_state_t st, input logic [4:0] idx,
                                            input logic [2:0] op, input logic [3:0] ri,
                                            input logic neg, input logic [19:0] digits);
        logic [4:0] col;
        logic [3:0] ones;
        logic [7:0] ch;
        logic [8:0] res;
        col  = idx - 5'd1;
        ones = (ri >= 4'd10) ? (ri - 4'd10) : ri;
        ch   = " ";
        res  = '0;
        case (st)
            ST_INIT: begin
                case (idx)
                    5'd0:    res = {1'b0, LCD_FUNC_SET};
                    5'd1:    res = {1'b0, LCD_DISP_ON};
                    5'd2:    res = {1'b0, LCD_CLEAR};
                    default: res = {1'b0, LCD_ENTRY};
                endcase
            end
            ST_LINE1: begin
                case (col)
                    5'd0, 5'd1, 5'd2, 5'd3, 5'd4: ch = mnemonic_char(op, col[2:0]);
                    5'd6:    ch = "R";
                    5'd7:    ch = (ri >= 4'd10) ? "1" : "0";
                    5'd8:    ch = 8'h30 | {4'h0, ones};
                    default: ch = " ";
                endcase
                res = (idx == 5'd0) ? {1'b0, LCD_LINE1} : {1'b1, ch};
            end
            ST_LINE2: begin
                case (col)
                    5'd0:    ch = neg ? "-" : "+";
                    5'd1:    ch = 8'h30 | {4'h0, digits[19:16]};
                    5'd2:    ch = 8'h30 | {4'h0, digits[15:12]};
                    5'd3:    ch = 8'h30 | {4'h0, digits[11:8]};
                    5'd4:    ch = 8'h30 | {4'h0, digits[7:4]};
                    5'd5:    ch = 8'h30 | {4'h0, digits[3:0]};
                    default: ch = " ";
                endcase
                res = (idx == 5'd0) ? {1'b0, LCD_LINE2} : {1'b1, ch};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cnt_n       = cnt;
        idx_n       = byte_idx;
        conv_wait_n = conv_wait;
        load_byte   = 1'b0;
        bcd_start   = 1'b0;
        disp_load   = 1'b0;
        hold_last   = (!lcd_rs && lcd_data == LCD_CLEAR) ? CLEAR_LAST : CMD_LAST;

        case (state)
            ST_POWERUP_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_n   = ST_INIT;
                    idx_n     = '0;
                    load_byte = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_INIT, ST_LINE1, ST_LINE2: begin
                case (phase)
                    PH_SETUP: begin
                        phase_n = PH_EN;
                        cnt_n   = '0;
                    end
                    PH_EN: begin
                        if (cnt == EN_LAST) begin
                            phase_n = PH_HOLD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt != hold_last) begin
                            cnt_n = cnt + 1'b1;
                        end else if ((state == ST_INIT && byte_idx == 5'd3) ||
                                     (state == ST_LINE2 && byte_idx == 5'd16)) begin
                            state_n = ST_IDLE;
                            phase_n = PH_SETUP;
                            cnt_n   = '0;
                        end else if (state == ST_LINE1 && byte_idx == 5'd16) begin
                            state_n   = ST_LINE2;
                            idx_n     = '0;
                            load_byte = 1'b1;
                        end else begin
                            idx_n     = byte_idx + 5'd1;
                            load_byte = 1'b1;
                        end
                    end
                endcase
            end
            ST_IDLE: begin
                if (start || pending) begin
                    state_n     = ST_CONVERT;
                    conv_wait_n = 1'b0;
                end
            end
            ST_CONVERT: begin
                // first CONVERT cycle kicks the converter from the captured
                // operands, so a start arriving as IDLE is entered is honoured
                if (!conv_wait) begin
                    if (!bcd_busy) begin
                        bcd_start   = 1'b1;
                        disp_load   = 1'b1;
                        conv_wait_n = 1'b1;
                    end
                end else if (bcd_done) begin
                    state_n   = ST_LINE1;
                    idx_n     = '0;
                    load_byte = 1'b1;
                end
            end
            default: state_n = ST_POWERUP_WAIT;
        endcase

        if (load_byte) begin
            phase_n = PH_SETUP;
            cnt_n   = '0;
        end

        next_byte = byte_for(state_n, idx_n, disp_opcode, disp_reg, disp_neg, bcd_digits);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_POWERUP_WAIT;
            phase     <= PH_SETUP;
            cnt       <= '0;
            byte_idx  <= '0;
            conv_wait <= 1'b0;
            lcd_data  <= '0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            cnt       <= cnt_n;
            byte_idx  <= idx_n;
            conv_wait <= conv_wait_n;
            lcd_en    <= (phase_n == PH_EN);
            if (load_byte)
                {lcd_rs, lcd_data} <= next_byte;
        end
    end

    // operand capture; the display snapshot is taken when conversion starts so a
    // refresh in flight stays self-consistent while new operands queue up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= 1'b0;
            cap_opcode  <= '0;
            cap_reg     <= '0;
            cap_value   <= '0;
            disp_opcode <= '0;
            disp_reg    <= '0;
            disp_neg    <= 1'b0;
        end else begin
            if (start) begin
                cap_opcode <= opcode;
                cap_reg    <= reg_idx;
                cap_value  <= value;
            end
            if (start && state != ST_IDLE)
                pending <= 1'b1;
            else if (state == ST_IDLE && state_n == ST_CONVERT)
                pending <= 1'b0;
            if (disp_load) begin
                disp_opcode <= cap_opcode;
                disp_reg    <= cap_reg;
                disp_neg    <= cap_value[15];
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

endmodule

// File: tb/tb_lcd_result_display.sv
module tb_lcd_result_display;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  opcode;
    logic [3:0]  reg_idx;
    logic [15:0] value;
    logic        busy;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    lcd_result_display #(
        .POWERUP_CYCLES    (100),
        .CMD_WAIT_CYCLES   (4),
        .CLEAR_WAIT_CYCLES (8),
        .EN_HIGH_CYCLES    (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .opcode   (opcode),
        .reg_idx  (reg_idx),
        .value    (value),
        .busy     (busy),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on),
        .lcd_blon (lcd_blon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // bus monitor: one entry per en rising edge
    logic [8:0] q[$];
    int         rq[$];
    int         wq[$];
    int         hi_cnt = 0;
    int         fall_cyc = 0;
    int         busy_fall = 0;
    logic       prev_en = 1'b0;
    logic       prev_busy = 1'b1;

    always @(negedge clk) begin
        if (lcd_en && !prev_en) begin
            q.push_back({lcd_rs, lcd_data});
            rq.push_back(cyc);
            hi_cnt = 1;
        end else if (lcd_en) begin
            hi_cnt++;
        end
        if (!lcd_en && prev_en) begin
            wq.push_back(hi_cnt);
            fall_cyc = cyc;
        end
        if (!busy && prev_busy)
            busy_fall = cyc;
        prev_en   = lcd_en;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bytes(input int n, input string tag);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (q.size() >= n && !busy) break;
        end
        @(negedge clk);
        check({tag, " byte count"}, q.size(), n);
        check({tag, " busy low"}, busy, 1'b0);
    endtask

    int s_cyc;

    task automatic pulse_start(input logic [2:0] op, input logic [3:0] ri, input logic [15:0] val);
        @(negedge clk);
        opcode  = op;
        reg_idx = ri;
        value   = val;
        start   = 1'b1;
        s_cyc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_init(input int base, input int rel, input string tag);
        check({tag, " byte0"}, q[base],     {1'b0, 8'h38});
        check({tag, " byte1"}, q[base + 1], {1'b0, 8'h0C});
        check({tag, " byte2"}, q[base + 2], {1'b0, 8'h01});
        check({tag, " byte3"}, q[base + 3], {1'b0, 8'h06});
        check({tag, " powerup wait"}, rq[base] - rel, 101);
        check({tag, " period 0x38"}, rq[base + 1] - rq[base], 7);
        check({tag, " period 0x0C"}, rq[base + 2] - rq[base + 1], 7);
        check({tag, " period after clear"}, rq[base + 3] - rq[base + 2], 11);
        check({tag, " en width"}, wq[base], 2);
        check({tag, " busy fall"}, busy_fall - rq[base + 3], 6);
    endtask

    task automatic check_lines(input int base, input logic [127:0] l1, input logic [127:0] l2, input string tag);
        logic [127:0] o1, o2;
        logic         rs1, rs2;
        o1  = '0;
        o2  = '0;
        rs1 = 1'b1;
        rs2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            o1[127 - 8*i -: 8] = q[base + 1 + i][7:0];
            o2[127 - 8*i -: 8] = q[base + 18 + i][7:0];
            rs1 = rs1 & q[base + 1 + i][8];
            rs2 = rs2 & q[base + 18 + i][8];
        end
        check({tag, " cmd line1"}, q[base], {1'b0, 8'h80});
        check({tag, " line1"}, o1, l1);
        check({tag, " line1 rs"}, rs1, 1'b1);
        check({tag, " cmd line2"}, q[base + 17], {1'b0, 8'hC0});
        check({tag, " line2"}, o2, l2);
        check({tag, " line2 rs"}, rs2, 1'b1);
    endtask

    task automatic do_refresh(input logic [2:0] op, input logic [3:0] ri, input logic [15:0] val,
                              input logic [127:0] l1, input logic [127:0] l2, input string tag);
        int base;
        base = q.size();
        pulse_start(op, ri, val);
        wait_bytes(base + 34, tag);
        check_lines(base, l1, l2, tag);
        check({tag, " latency bound"}, (fall_cyc - s_cyc) <= 258, 1'b1);
    endtask

    initial begin
        int rel;
        int base;
        reset_n = 1'b0;
        start   = 1'b0;
        opcode  = '0;
        reg_idx = '0;
        value   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b1);
        check("reset en", lcd_en, 1'b0);
        check("reset rs", lcd_rs, 1'b0);
        check("reset rw", lcd_rw, 1'b0);
        check("reset data", lcd_data, 8'h00);
        check("reset lcd_on", lcd_on, 1'b1);
        check("reset blon", lcd_blon, 1'b1);

        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        @(negedge clk);
        check("busy during powerup", busy, 1'b1);
        wait_bytes(4, "init");
        check_init(0, rel, "init");

        do_refresh(3'd1, 4'd3,  16'd12,   "ADD   R03       ", "+00012          ", "r1");
        do_refresh(3'd0, 4'd0,  16'hFFF6, "LOAD  R00       ", "-00010          ", "r2");
        do_refresh(3'd5, 4'd9,  16'h8000, "MUL   R09       ", "-32768          ", "r3");
        do_refresh(3'd3, 4'd12, 16'h7FFF, "SUB   R12       ", "+32767          ", "r4");
        do_refresh(3'd7, 4'd15, 16'h0000, "DISP  R15       ", "+00000          ", "r5");
        do_refresh(3'd6, 4'd10, 16'd1234, "CLEAR R10       ", "+01234          ", "r6");
        do_refresh(3'd2, 4'd1,  16'hFB2E, "ADDI  R01       ", "-01234          ", "r7");

        // two starts during a refresh: one deferred refresh with the last operands
        base = q.size();
        pulse_start(3'd1, 4'd3, 16'd12);
        repeat (30) @(negedge clk);
        pulse_start(3'd2, 4'd7, 16'd5);
        repeat (30) @(negedge clk);
        pulse_start(3'd4, 4'd10, 16'd9);
        wait_bytes(base + 68, "deferred");
        check_lines(base + 34, "SUBI  R10       ", "+00009          ", "deferred");
        repeat (400) @(negedge clk);
        check("no third refresh", q.size(), base + 68);

        // reset while en is high in the middle of a character
        base = q.size();
        pulse_start(3'd1, 4'd3, 16'd12);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lcd_en && q.size() >= base + 6) break;
        end
        check("mid-char en high", lcd_en && (q.size() >= base + 6), 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async en drop", lcd_en, 1'b0);
        check("async busy", busy, 1'b1);
        check("async data", lcd_data, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rel  = cyc;
        base = q.size();
        wait_bytes(base + 4, "reinit");
        check_init(base, rel, "reinit");
        repeat (500) @(negedge clk);
        check("no data after reinit", q.size(), base + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_result_display.md
Name: lcd_result_display

Overview:
- Downstream display stage of the mini CPU. Consumes the one-cycle `start` pulse and the registered opcode, register index and 16-bit result.
- Drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode.
  - Line 1: instruction mnemonic and register index.
  - Line 2: value as signed decimal.
- Performs the power-up init sequence itself. Exposes `busy` for status and debug.

Parameters:
- POWERUP_CYCLES, 750000: wait after reset before the first command (15 ms at 50 MHz).
- CMD_WAIT_CYCLES, 2000: hold after each byte except clear (40 us).
- CLEAR_WAIT_CYCLES, 82000: hold after the 0x01 clear command (1.64 ms).
- EN_HIGH_CYCLES, 16: width of the lcd_en high pulse (320 ns).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to refresh the display
- opcode  in  3  instruction opcode to show
- reg_idx  in  4  register index to show, 0..15
- value  in  16  two's-complement value to show
- busy  out  1  high during init, conversion or refresh
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  0 = command, 1 = character
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_on  out  1  tied 1
- lcd_blon  out  1  tied 1

Behaviour:
- One clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - state=POWERUP_WAIT, busy=1, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=1, lcd_blon=1.
  - pending=0; captured operands cleared to opcode 0, reg 0, value 0.
- reset_n low at any time, including mid-pulse: lcd_en drops immediately and the full init restarts from POWERUP_WAIT.
- Byte write primitive, used for every byte:
  - 1 setup cycle: data and rs driven, en=0.
  - EN_HIGH_CYCLES cycles: en=1.
  - Hold cycles with en=0: CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES after 0x01.
  - data and rs stay stable for the whole byte.
- States:
  - POWERUP_WAIT: count POWERUP_CYCLES, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x01, 0x06 in order, then go to IDLE.
  - IDLE: busy=0. If start or pending, go to CONVERT.
  - CONVERT: sub-module converts |value| to 5 BCD digits, then go to LINE1.
  - LINE1: command 0x80, then 16 characters, then go to LINE2.
  - LINE2: command 0xC0, then 16 characters, then go to IDLE.
- Operand capture:
  - A start pulse in any state copies opcode, reg_idx and value into internal registers.
  - If the pulse is not in IDLE, it also sets pending.
  - pending clears when CONVERT is entered. Last capture wins; at most one deferred refresh.
  - start in the same cycle that IDLE is entered begins CONVERT on the next cycle with the new operands.
- Line 1 layout, 16 ASCII characters:
  - cols 0-4: mnemonic by opcode, space-padded: 0 "LOAD ", 1 "ADD  ", 2 "ADDI ", 3 "SUB  ", 4 "SUBI ", 5 "MUL  ", 6 "CLEAR", 7 "DISP ".
  - col 5: ' '.
  - col 6: 'R'.
  - cols 7-8: reg_idx as two decimal digits, 00..15.
  - cols 9-15: spaces.
- Line 2 layout:
  - col 0: '-' if value[15]=1, else '+'.
  - cols 1-5: magnitude as 5 decimal digits with leading zeros.
  - cols 6-15: spaces.
- Magnitude arithmetic:
  - Magnitude = value[15] ? (~value + 1) : value, computed as 16-bit unsigned.
  - 0x8000 yields 32768 and displays "-32768".
  - 0 displays "+00000".
- Refresh timing:
  - 34 bytes per refresh.
  - Latency from start in IDLE to the final en falling edge is deterministic: ≤ 20 + 34*(1 + EN_HIGH_CYCLES + CMD_WAIT_CYCLES) cycles.
  - busy deasserts on the cycle IDLE is re-entered.

Decomposition:
- Shared package `mini_cpu_pkg`:
  - opcode constants LOAD..DISPLAY = 0..7;
  - LCD command bytes FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, LINE1 0x80, LINE2 0xC0;
  - state enum;
  - mnemonic ROM function (opcode to 5 characters).
- Sub-module `bcd_converter_16`:
  - Sequential double-dabble with start/done handshake.
  - Input: 16-bit unsigned. Output: 5 BCD digits.
  - Exactly 16 iteration cycles plus 1 done cycle.
  - A start while it is converting is ignored.

Test Plan:
Bench parameters: POWERUP 100, CMD_WAIT 4, CLEAR_WAIT 8, EN_HIGH 2.
- Release reset -> busy=1; after 100 cycles, bytes 0x38, 0x0C, 0x01, 0x06 with rs=0; 8-cycle hold after 0x01; busy=0 after 0x06 hold.
- start with opcode=1, reg_idx=3, value=12 -> 0x80, then "ADD   R03       " with rs=1, then 0xC0, then "+00012          "; busy low afterwards.
- value 0xFFF6 -> "-00010"; 0x8000 -> "-32768"; 0x7FFF -> "+32767"; 0x0000 -> "+00000".
- opcode=7, reg_idx=15 -> line 1 "DISP  R15       "; opcode=6 -> "CLEAR R..".
- Two starts during a refresh (values 5, then 9) -> exactly one extra refresh, showing "+00009".
- reset_n low while en=1 mid-character -> en=0 at once; after release, the full POWERUP and INIT sequence repeats, and no line data is emitted until a new start.
